// File: rtl/dm_ext_if.sv
// dm_ext_if: load/store port of the extended data memory, pipeline side is master.
interface dm_ext_if;
  logic        Wr;
  logic        Rd;
  logic [2:0]  Mode;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] PC;
  logic [31:0] DR;
  logic        busy;
  logic        err_load;
  logic        err_store;
  modport master (output Wr, Rd, Mode, A, WD, PC, input DR, busy, err_load, err_store);
  modport slave  (input Wr, Rd, Mode, A, WD, PC, output DR, busy, err_load, err_store);
endinterface

// File: rtl/dm_ext.sv
// dm_ext: word memory with byte/half lanes, extended loads, fault flags and a swept clear on reset.
// Define DM_EXT_TRACE_EN to print one line per committed store.
module dm_ext #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  dm_ext_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       mem_q [2**ADDR_W];
  logic [31:0]       off, rdata, wdata, bmask;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [15:0]       half;
  logic [7:0]        byt;
  logic [4:0]        sh;
  logic              is_w, is_h, is_b, mis, oor, busy, we;
  always_comb begin
    off   = bus.A - BASE_ADDR;
    idx   = off[ADDR_W+1:2];
    lane  = off[1:0];
    is_w  = bus.Mode == 3'd0;
    is_h  = bus.Mode == 3'd1 || bus.Mode == 3'd2;
    is_b  = bus.Mode == 3'd3 || bus.Mode == 3'd4;
    oor   = |off[31:ADDR_W+2];
    mis   = is_w ? |lane : is_h ? lane[0] : !is_b;
    busy  = state_q == CLEAR;
    rdata = mem_q[idx];
    half  = lane[1] ? rdata[31:16] : rdata[15:0];
    byt   = 8'(rdata >> {lane, 3'b000});
    sh    = is_w ? 5'd0 : is_h ? {lane[1], 4'b0000} : {lane, 3'b000};
    bmask = (is_w ? 32'hFFFF_FFFF : is_h ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    wdata = (rdata & ~bmask) | ((bus.WD << sh) & bmask);
    we    = bus.Wr && !busy && !oor && !mis && !rst;
    bus.busy      = busy;
    bus.err_load  = !busy && bus.Rd && (oor || mis);
    bus.err_store = !busy && bus.Wr && (oor || mis);
    bus.DR = (busy || oor || mis) ? 32'h0 :
             is_w                 ? rdata :
             bus.Mode == 3'd1     ? {16'h0, half} :
             bus.Mode == 3'd2     ? {{16{half[15]}}, half} :
             bus.Mode == 3'd3     ? {24'h0, byt} :
                                    {{24{byt[7]}}, byt};
    state_d = rst ? CLEAR : (busy && &ptr_q) ? IDLE : state_q;
    ptr_d   = rst ? '0 : busy ? ptr_q + 1'b1 : ptr_q;
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
    if (!rst && busy) mem_q[ptr_q] <= '0;
    else if (we) mem_q[idx] <= wdata;
`ifdef DM_EXT_TRACE_EN
    if (we) $display("%d@%h: *%h <= %h", $time, bus.PC, {bus.A[31:2], 2'b00}, wdata);
`endif
  end
`ifndef DM_EXT_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^bus.PC;
`endif
endmodule

// File: tb/tb_dm_ext.sv
// tb_dm_ext: directed stimulus against a byte-level memory model, checked every cycle plus literal pins.
module tb_dm_ext;
  logic clk = 0, rst = 1;
  dm_ext_if bus();
  dm_ext #(.ADDR_W(4), .BASE_ADDR(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  logic [31:0] m [16];
  bit mbusy = 0, started = 0;
  int cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic int size_of(input logic [2:0] mode);
    return mode == 0 ? 4 : mode <= 2 ? 2 : 1;
  endfunction
  function automatic bit f_mis(input logic [2:0] mode, input logic [31:0] a);
    if (mode > 4) return 1;
    return (a % size_of(mode)) != 0;
  endfunction
  function automatic bit f_oor(input logic [31:0] a);
    return (a / 64) != 0;
  endfunction
  function automatic logic [31:0] exp_dr(input logic [2:0] mode, input logic [31:0] a);
    logic [31:0] v, mask;
    int n;
    if (mbusy || f_oor(a) || f_mis(mode, a)) return 0;
    n = size_of(mode);
    mask = n == 4 ? 32'hFFFF_FFFF : n == 2 ? 32'h0000_FFFF : 32'h0000_00FF;
    v = (m[a / 4] >> (8 * (a % 4))) & mask;
    if ((mode == 2 || mode == 4) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mbusy = 1; cnt = 0; started = 1;
    end else if (mbusy) begin
      m[cnt] = 0; cnt++;
      if (cnt == 16) begin mbusy = 0; cnt = 0; end
    end else if (bus.Wr && !f_oor(bus.A) && !f_mis(bus.Mode, bus.A)) begin
      logic [31:0] w;
      int base;
      w = m[bus.A / 4];
      base = bus.A % 4;
      for (int i = 0; i < size_of(bus.Mode); i++) w[8*(base+i) +: 8] = bus.WD[8*i +: 8];
      m[bus.A / 4] = w;
    end
  end

  always @(negedge clk) if (started) begin
    bit fault;
    fault = f_oor(bus.A) || f_mis(bus.Mode, bus.A);
    check("cmp_busy", {31'b0, bus.busy}, {31'b0, mbusy});
    check("cmp_dr", bus.DR, exp_dr(bus.Mode, bus.A));
    check("cmp_err_load", {31'b0, bus.err_load}, {31'b0, !mbusy && bus.Rd && fault});
    check("cmp_err_store", {31'b0, bus.err_store}, {31'b0, !mbusy && bus.Wr && fault});
  end

  task automatic step(input bit wr, input bit rd, input logic [2:0] mode, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.Wr = wr; bus.Rd = rd; bus.Mode = mode; bus.A = a; bus.WD = wd;
    @(negedge clk);
  endtask
  task automatic rd_chk(input string name, input logic [2:0] mode, input logic [31:0] a, input logic [31:0] exp);
    step(0, 1, mode, a, 0);
    check(name, bus.DR, exp);
  endtask
  task automatic count_busy(output int n, input int limit);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      #1;
      if (n == 3) begin bus.Wr = 1; bus.Mode = 0; bus.A = 0; bus.WD = 32'h1234; end
      if (n == 4) bus.Wr = 0;
    end
  endtask

  initial begin
    int n;
    bus.Wr = 0; bus.Rd = 0; bus.Mode = 0; bus.A = 0; bus.WD = 0; bus.PC = 32'h3000;
    @(posedge clk); #1 rst = 0;
    check("reset_busy", {31'b0, bus.busy}, 32'd1);
    check("reset_dr", bus.DR, 32'h0);
    check("reset_err", {30'b0, bus.err_load, bus.err_store}, 32'h0);
    count_busy(n, 40);
    check("sweep_len", n, 16);
    for (int i = 0; i < 16; i++) rd_chk("sweep_zero", 0, 4 * i, 32'h0);
    step(1, 0, 0, 32'h8, 32'hDEADBEEF);
    rd_chk("word_load", 0, 32'h8, 32'hDEADBEEF);
    rd_chk("word_other", 0, 32'hC, 32'h0);
    step(1, 0, 0, 32'h0, 32'hDEADBEEF);
    step(1, 0, 3, 32'h1, 32'h55);
    rd_chk("byte_store", 0, 32'h0, 32'hDEAD55EF);
    step(1, 0, 1, 32'h2, 32'hA5A5);
    rd_chk("half_store", 0, 32'h0, 32'hA5A555EF);
    rd_chk("lb_signed", 4, 32'h3, 32'hFFFFFFA5);
    rd_chk("lb_unsigned", 3, 32'h3, 32'h000000A5);
    rd_chk("lh_signed", 2, 32'h0, 32'h000055EF);
    rd_chk("lh_hi_signed", 2, 32'h2, 32'hFFFFA5A5);
    step(1, 0, 0, 32'h4, 32'h11111111);
    step(1, 0, 0, 32'h6, 32'hFFFFFFFF);
    check("mis_store_flag", {31'b0, bus.err_store}, 32'd1);
    rd_chk("mis_store_nochg", 0, 32'h4, 32'h11111111);
    rd_chk("mis_load_dr", 1, 32'h3, 32'h0);
    check("mis_load_flag", {31'b0, bus.err_load}, 32'd1);
    rd_chk("oor_load_dr", 0, 32'h40, 32'h0);
    check("oor_load_flag", {31'b0, bus.err_load}, 32'd1);
    step(1, 0, 0, 32'h40, 32'h0BADF00D);
    check("oor_store_flag", {31'b0, bus.err_store}, 32'd1);
    step(1, 0, 6, 32'h0, 32'h0BADF00D);
    check("mode6_store_flag", {31'b0, bus.err_store}, 32'd1);
    rd_chk("fault_nochg", 0, 32'h0, 32'hA5A555EF);
    step(1, 0, 0, 32'h3C, 32'hCAFEF00D);
    rd_chk("pre_reset_word", 0, 32'h3C, 32'hCAFEF00D);
    step(0, 0, 0, 32'h3C, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 7; i++) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    count_busy(n, 40);
    check("resweep_len", n, 16);
    rd_chk("resweep_w15", 0, 32'h3C, 32'h0);
    rd_chk("resweep_w2", 0, 32'h8, 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
